// File: rtl/reaction_pkg.sv
// reaction_pkg
// Shared definitions for the reaction-time game controller.
//   - state_e    : FSM state codes, numerically identical to the HEX5 display codes
//   - DIGIT_W    : width of one BCD digit
//   - BEST_INIT  : best-score value at the start of every game (BCD 999)
//   - LFSR_SEED  : power-up value of the random-delay LFSR
//   - lfsr_next  : one step of the 11-bit Fibonacci LFSR (x^11 + x^9 + 1)
package reaction_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WAIT   = 4'd1,
    ST_TIMING = 4'd2,
    ST_SHOW   = 4'd3,
    ST_BEST   = 4'd4,
    ST_FAULT  = 4'd5
  } state_e;

  localparam int          DIGIT_W   = 4;
  localparam logic [11:0] BEST_INIT = 12'h999;
  localparam logic [10:0] LFSR_SEED = 11'h5A5;

  // Shift left, feed back bit10 ^ bit8; a non-zero state never maps to zero.
  function automatic logic [10:0] lfsr_next(input logic [10:0] v);
    return {v[9:0], v[10] ^ v[8]};
  endfunction

endpackage

// File: rtl/bcd_counter_3.sv
// bcd_counter_3
// Three-digit BCD up-counter that sticks at 999.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset, clears the count to 000
//   clr_i  - synchronous clear to 000 (wins over inc_i)
//   inc_i  - add one, with decimal ripple carry between digits
//   d2_o   - hundreds digit
//   d1_o   - tens digit
//   d0_o   - units digit
//   sat_o  - high while the count is 999
module bcd_counter_3
  import reaction_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [DIGIT_W-1:0] d2_o,
  output logic [DIGIT_W-1:0] d1_o,
  output logic [DIGIT_W-1:0] d0_o,
  output logic               sat_o
);

  logic [DIGIT_W-1:0] d2_q, d1_q, d0_q;
  logic [DIGIT_W-1:0] d2_d, d1_d, d0_d;

  assign sat_o = (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd9);

  // Increments are dropped once saturated, so the hundreds digit never wraps.
  always_comb begin
    d2_d = d2_q;
    d1_d = d1_q;
    d0_d = d0_q;
    if (clr_i) begin
      d2_d = '0;
      d1_d = '0;
      d0_d = '0;
    end else if (inc_i && !sat_o) begin
      if (d0_q == 4'd9) begin
        d0_d = '0;
        if (d1_q == 4'd9) begin
          d1_d = '0;
          d2_d = d2_q + 4'd1;
        end else begin
          d1_d = d1_q + 4'd1;
        end
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d2_q <= '0;
      d1_q <= '0;
      d0_q <= '0;
    end else begin
      d2_q <= d2_d;
      d1_q <= d1_d;
      d0_q <= d0_d;
    end
  end

  assign d2_o = d2_q;
  assign d1_o = d1_q;
  assign d0_o = d0_q;

endmodule

// File: rtl/reaction_round_controller.sv
// reaction_round_controller
// Multi-round reaction-time game sequencer: IDLE -> WAIT (random delay) ->
// TIMING (stimulus lamp, ms counter) -> SHOW (score) -> next round or BEST.
// A react press during WAIT is a false start and goes through FAULT.
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   key_start_n           - raw start button, active-low
//   key_react_n           - raw react button, active-low
//   state_code            - current state (0 IDLE .. 5 FAULT) for HEX5
//   stim_led              - stimulus lamp, lit only in TIMING
//   false_start           - high while in FAULT
//   score_d2/d1/d0        - last reaction time, BCD ms
//   best_d2/d1/d0         - best time of the current game, BCD ms
//   score_valid           - one-cycle pulse on the first SHOW cycle
//   new_best              - high for the whole SHOW visit when best improved
//   round_idx             - current round, 0-based
module reaction_round_controller
  import reaction_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int ROUNDS       = 3,
  parameter int SHOW_MS      = 2000,
  parameter int FAULT_MS     = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_react_n,
  output logic [3:0] state_code,
  output logic       stim_led,
  output logic       false_start,
  output logic [3:0] score_d2,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [3:0] best_d2,
  output logic [3:0] best_d1,
  output logic [3:0] best_d0,
  output logic       score_valid,
  output logic       new_best,
  output logic [1:0] round_idx
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DELAY_W  = 16;
  localparam int HOLD_W   = 16;

  // Button synchronizers; flops idle high because the buttons are active-low.
  logic start_s1_q, start_s2_q, start_s3_q;
  logic react_s1_q, react_s2_q, react_s3_q;
  logic start_press, react_press, react_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_s1_q <= 1'b1;
      start_s2_q <= 1'b1;
      start_s3_q <= 1'b1;
      react_s1_q <= 1'b1;
      react_s2_q <= 1'b1;
      react_s3_q <= 1'b1;
    end else begin
      start_s1_q <= key_start_n;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      react_s1_q <= key_react_n;
      react_s2_q <= react_s1_q;
      react_s3_q <= react_s2_q;
    end
  end

  // Falling edge of the synchronized level; start has priority over react.
  assign start_press = start_s3_q & ~start_s2_q;
  assign react_press = react_s3_q & ~react_s2_q;
  assign react_eff   = react_press & ~start_press;

  state_e               state_q, state_d;
  logic [1:0]           round_q, round_d;
  logic [DELAY_W-1:0]   delay_q, delay_d, fresh_delay;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [11:0]          score_q, score_d;
  logic [11:0]          best_q, best_d;
  logic                 new_best_q, new_best_d;
  logic                 score_valid_q, score_valid_d;
  logic [10:0]          lfsr_q;
  logic                 tick;
  logic                 cnt_clr, cnt_inc, cnt_sat;
  logic [3:0]           cnt_d2, cnt_d1, cnt_d0;
  logic [11:0]          cnt_val;

  bcd_counter_3 u_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .d2_o  (cnt_d2),
    .d1_o  (cnt_d1),
    .d0_o  (cnt_d0),
    .sat_o (cnt_sat)
  );

  assign cnt_val     = {cnt_d2, cnt_d1, cnt_d0};
  assign tick        = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign fresh_delay = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q);

  // Next-state logic. A WAIT delay of N ticks expires on the tick that would
  // take it to zero, so WAIT lasts exactly N*TICK_DIV cycles.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    delay_d       = delay_q;
    hold_d        = hold_q;
    score_d       = score_q;
    best_d        = best_q;
    new_best_d    = new_best_q;
    score_valid_d = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d = ST_WAIT;
          round_d = 2'd0;
          delay_d = fresh_delay;
        end
      end

      ST_WAIT: begin
        if (react_eff) begin
          state_d = ST_FAULT;
        end else if (tick) begin
          if (delay_q <= DELAY_W'(1)) begin
            state_d = ST_TIMING;
            delay_d = '0;
            cnt_clr = 1'b1;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end
      end

      ST_TIMING: begin
        cnt_inc = tick;
        // The counter value is still pre-increment here, which is what a
        // press coinciding with a tick must record.
        if (react_eff || cnt_sat) begin
          state_d       = ST_SHOW;
          score_d       = cnt_val;
          score_valid_d = 1'b1;
          // Packed BCD orders the same way as the decimal value it encodes.
          if (cnt_val < best_q) begin
            best_d     = cnt_val;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
        end
      end

      ST_SHOW: begin
        if (start_press || (tick && (hold_q == HOLD_W'(SHOW_MS - 1)))) begin
          new_best_d = 1'b0;
          if (round_q < 2'(ROUNDS - 1)) begin
            state_d = ST_WAIT;
            round_d = round_q + 2'd1;
            delay_d = fresh_delay;
          end else begin
            state_d = ST_BEST;
          end
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_BEST: begin
        if (start_press) begin
          state_d = ST_IDLE;
          best_d  = BEST_INIT;
          round_d = 2'd0;
        end
      end

      ST_FAULT: begin
        if (tick) begin
          if (hold_q == HOLD_W'(FAULT_MS - 1)) begin
            state_d = ST_WAIT;
            delay_d = fresh_delay;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state entry restarts the hold counter.
    if (state_d != state_q) begin
      hold_d = '0;
    end
  end

  // Prescaler restarts on each state entry so the first tick of a state
  // arrives TICK_DIV cycles after entering it.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if ((state_d != state_q) || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      round_q       <= 2'd0;
      delay_q       <= '0;
      hold_q        <= '0;
      presc_q       <= '0;
      score_q       <= 12'h000;
      best_q        <= BEST_INIT;
      new_best_q    <= 1'b0;
      score_valid_q <= 1'b0;
      lfsr_q        <= LFSR_SEED;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      delay_q       <= delay_d;
      hold_q        <= hold_d;
      presc_q       <= presc_d;
      score_q       <= score_d;
      best_q        <= best_d;
      new_best_q    <= new_best_d;
      score_valid_q <= score_valid_d;
      lfsr_q        <= lfsr_next(lfsr_q);
    end
  end

  assign state_code  = state_q;
  assign stim_led    = (state_q == ST_TIMING);
  assign false_start = (state_q == ST_FAULT);
  assign score_d2    = score_q[11:8];
  assign score_d1    = score_q[7:4];
  assign score_d0    = score_q[3:0];
  assign best_d2     = best_q[11:8];
  assign best_d1     = best_q[7:4];
  assign best_d0     = best_q[3:0];
  assign score_valid = score_valid_q;
  assign new_best    = new_best_q;
  assign round_idx   = round_q;

endmodule

// File: tb/tb_reaction_round_controller.sv
// tb_reaction_round_controller
// Directed bench for reaction_round_controller with a 4-cycle ms tick,
// 2 ms minimum wait, 3 ms score hold, 2 ms false-start hold and 2 rounds.
module tb_reaction_round_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_react_n = 1'b1;
  logic [3:0] state_code;
  logic       stim_led, false_start, score_valid, new_best;
  logic [3:0] score_d2, score_d1, score_d0, best_d2, best_d1, best_d0;
  logic [1:0] round_idx;

  int checks = 0;
  int errors = 0;

  // Reference copy of the delay LFSR; lfsrPrev is the value that was live
  // during the cycle before the most recent rising edge.
  logic [10:0] lfsrModel, lfsrPrev;

  reaction_round_controller #(
    .CLK_HZ       (4000),
    .MIN_DELAY_MS (2),
    .ROUNDS       (2),
    .SHOW_MS      (3),
    .FAULT_MS     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_start_n (key_start_n),
    .key_react_n (key_react_n),
    .state_code  (state_code),
    .stim_led    (stim_led),
    .false_start (false_start),
    .score_d2    (score_d2),
    .score_d1    (score_d1),
    .score_d0    (score_d0),
    .best_d2     (best_d2),
    .best_d1     (best_d1),
    .best_d0     (best_d0),
    .score_valid (score_valid),
    .new_best    (new_best),
    .round_idx   (round_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsrModel = 11'h5A5;
      lfsrPrev  = 11'h5A5;
    end else begin
      lfsrPrev  = lfsrModel;
      lfsrModel = {lfsrModel[9:0], lfsrModel[10] ^ lfsrModel[8]};
    end
  end

  // Drives the raw buttons; argument 1 means "held down".
  task automatic applyStimulus(input logic pressStart, input logic pressReact);
    key_start_n = ~pressStart;
    key_react_n = ~pressReact;
  endtask

  // Steps falling edges until state_code leaves cur; n counts the edges.
  task automatic waitChange(input logic [3:0] cur, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_code == cur && n < budget);
    if (state_code == cur) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout leaving state %0d: still %0d after %0d cycles", cur, state_code, n);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (state_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state_code); end
    checks++; if (stim_led !== 1'b0) begin errors++; $display("[TB] FAIL reset_stim: got %b want 0", stim_led); end
    checks++; if ({best_d2, best_d1, best_d0} !== 12'h999) begin errors++; $display("[TB] FAIL reset_best: got %h want 999", {best_d2, best_d1, best_d0}); end
    checks++; if ({score_d2, score_d1, score_d0} !== 12'h000) begin errors++; $display("[TB] FAIL reset_score: got %h want 000", {score_d2, score_d1, score_d0}); end
    checks++; if ({score_valid, new_best, false_start, round_idx} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 00000", {score_valid, new_best, false_start, round_idx}); end
    // A react press in IDLE must be ignored.
    applyStimulus(1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (state_code !== 4'd0) begin errors++; $display("[TB] FAIL idle_react_ignored: got %0d want 0", state_code); end
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n = 0;
  endtask

  // Starts a game from IDLE or BEST and returns the LFSR sample used.
  task automatic startGame(input logic [3:0] from, output int sample);
    int n;
    applyStimulus(1'b1, 1'b0);
    waitChange(from, 20, n);
    applyStimulus(1'b0, 1'b0);
    sample = int'(lfsrPrev);
  endtask

  // Sits in WAIT (entered at the current edge) until TIMING, checking length.
  task automatic expectWaitToTiming(input int sample, input string tag);
    int n;
    waitChange(4'd1, 9000, n);
    checks++; if (n !== (2 + sample) * 4) begin errors++; $display("[TB] FAIL %s_wait_len: got %0d want %0d", tag, n, (2 + sample) * 4); end
    checks++; if (state_code !== 4'd2 || stim_led !== 1'b1) begin errors++; $display("[TB] FAIL %s_timing: got state %0d stim %b want 2 1", tag, state_code, stim_led); end
  endtask

  task automatic test_round_one();
    int n, s;
    applyStimulus(1'b1, 1'b0);
    waitChange(4'd0, 20, n);
    applyStimulus(1'b0, 1'b0);
    s = int'(lfsrPrev);
    checks++; if (state_code !== 4'd1 || round_idx !== 2'd0) begin errors++; $display("[TB] FAIL start_wait: got state %0d round %0d want 1 0", state_code, round_idx); end
    expectWaitToTiming(s, "r0");
    repeat (147) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    waitChange(4'd2, 20, n);
    applyStimulus(1'b0, 1'b0);
    checks++; if (state_code !== 4'd3) begin errors++; $display("[TB] FAIL r0_show: got %0d want 3", state_code); end
    checks++; if ({score_d2, score_d1, score_d0} !== 12'h037) begin errors++; $display("[TB] FAIL r0_score: got %h want 037", {score_d2, score_d1, score_d0}); end
    checks++; if (score_valid !== 1'b1 || new_best !== 1'b1) begin errors++; $display("[TB] FAIL r0_flags: got valid %b newbest %b want 1 1", score_valid, new_best); end
    checks++; if ({best_d2, best_d1, best_d0} !== 12'h037) begin errors++; $display("[TB] FAIL r0_best: got %h want 037", {best_d2, best_d1, best_d0}); end
    @(negedge clk);
    checks++; if (score_valid !== 1'b0 || new_best !== 1'b1) begin errors++; $display("[TB] FAIL r0_pulse: got valid %b newbest %b want 0 1", score_valid, new_best); end
    waitChange(4'd3, 50, n);
    checks++; if (n !== 11 || state_code !== 4'd1 || round_idx !== 2'd1) begin errors++; $display("[TB] FAIL r0_show_exit: got n %0d state %0d round %0d want 11 1 1", n, state_code, round_idx); end
  endtask

  task automatic test_round_two();
    int n, s;
    s = int'(lfsrPrev);
    expectWaitToTiming(s, "r1");
    repeat (207) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    waitChange(4'd2, 20, n);
    applyStimulus(1'b0, 1'b0);
    checks++; if ({score_d2, score_d1, score_d0} !== 12'h052) begin errors++; $display("[TB] FAIL r1_score: got %h want 052", {score_d2, score_d1, score_d0}); end
    checks++; if (score_valid !== 1'b1 || new_best !== 1'b0) begin errors++; $display("[TB] FAIL r1_flags: got valid %b newbest %b want 1 0", score_valid, new_best); end
    checks++; if ({best_d2, best_d1, best_d0} !== 12'h037) begin errors++; $display("[TB] FAIL r1_best: got %h want 037", {best_d2, best_d1, best_d0}); end
    waitChange(4'd3, 50, n);
    checks++; if (n !== 12 || state_code !== 4'd4) begin errors++; $display("[TB] FAIL r1_to_best: got n %0d state %0d want 12 4", n, state_code); end
  endtask

  task automatic test_best_restart();
    int n;
    repeat (5) @(negedge clk);
    checks++; if (state_code !== 4'd4) begin errors++; $display("[TB] FAIL best_hold: got %0d want 4", state_code); end
    applyStimulus(1'b1, 1'b0);
    waitChange(4'd4, 20, n);
    applyStimulus(1'b0, 1'b0);
    checks++; if (state_code !== 4'd0 || {best_d2, best_d1, best_d0} !== 12'h999 || round_idx !== 2'd0) begin errors++; $display("[TB] FAIL best_restart: got state %0d best %h round %0d want 0 999 0", state_code, {best_d2, best_d1, best_d0}, round_idx); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_false_start();
    int n, s;
    startGame(4'd0, s);
    applyStimulus(1'b0, 1'b1);
    waitChange(4'd1, 20, n);
    applyStimulus(1'b0, 1'b0);
    checks++; if (n !== 3 || state_code !== 4'd5 || false_start !== 1'b1) begin errors++; $display("[TB] FAIL fault_entry: got n %0d state %0d fs %b want 3 5 1", n, state_code, false_start); end
    waitChange(4'd5, 50, n);
    checks++; if (n !== 8 || state_code !== 4'd1 || false_start !== 1'b0) begin errors++; $display("[TB] FAIL fault_exit: got n %0d state %0d fs %b want 8 1 0", n, state_code, false_start); end
    checks++; if (round_idx !== 2'd0 || {score_d2, score_d1, score_d0} !== 12'h052) begin errors++; $display("[TB] FAIL fault_keep: got round %0d score %h want 0 052", round_idx, {score_d2, score_d1, score_d0}); end
  endtask

  task automatic test_coincide();
    int n, d;
    d = 2 + int'(lfsrPrev);
    repeat (4 * d - 3) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    waitChange(4'd1, 20, n);
    applyStimulus(1'b0, 1'b0);
    checks++; if (n !== 3 || state_code !== 4'd5) begin errors++; $display("[TB] FAIL coincide_fault: got n %0d state %0d want 3 5", n, state_code); end
    waitChange(4'd5, 50, n);
  endtask

  task automatic test_timeout();
    int n, s;
    s = int'(lfsrPrev);
    expectWaitToTiming(s, "g2r0");
    repeat (39) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    waitChange(4'd2, 20, n);
    applyStimulus(1'b0, 1'b0);
    checks++; if ({score_d2, score_d1, score_d0, best_d2, best_d1, best_d0} !== 24'h010010 || new_best !== 1'b1) begin errors++; $display("[TB] FAIL g2r0_score: got score %h best %h nb %b want 010 010 1", {score_d2, score_d1, score_d0}, {best_d2, best_d1, best_d0}, new_best); end
    waitChange(4'd3, 50, n);
    s = int'(lfsrPrev);
    expectWaitToTiming(s, "g2r1");
    waitChange(4'd2, 5000, n);
    checks++; if (n !== 3997 || state_code !== 4'd3) begin errors++; $display("[TB] FAIL timeout_len: got n %0d state %0d want 3997 3", n, state_code); end
    checks++; if ({score_d2, score_d1, score_d0} !== 12'h999 || score_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_score: got %h valid %b want 999 1", {score_d2, score_d1, score_d0}, score_valid); end
    checks++; if ({best_d2, best_d1, best_d0} !== 12'h010 || new_best !== 1'b0) begin errors++; $display("[TB] FAIL timeout_best: got %h nb %b want 010 0", {best_d2, best_d1, best_d0}, new_best); end
    waitChange(4'd3, 50, n);
  endtask

  task automatic test_async_reset();
    int n, s;
    startGame(4'd4, s);
    repeat (4) @(negedge clk);
    startGame(4'd0, s);
    expectWaitToTiming(s, "g3");
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (state_code !== 4'd0 || stim_led !== 1'b0) begin errors++; $display("[TB] FAIL async_state: got state %0d stim %b want 0 0", state_code, stim_led); end
    checks++; if ({score_d2, score_d1, score_d0} !== 12'h000 || {best_d2, best_d1, best_d0} !== 12'h999 || round_idx !== 2'd0) begin errors++; $display("[TB] FAIL async_regs: got score %h best %h round %0d want 000 999 0", {score_d2, score_d1, score_d0}, {best_d2, best_d1, best_d0}, round_idx); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state_code !== 4'd0) begin errors++; $display("[TB] FAIL async_release: got %0d want 0", state_code); end
    n = 0;
  endtask

  initial begin
    test_reset();
    test_round_one();
    test_round_two();
    test_best_restart();
    test_false_start();
    test_coincide();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
